// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter sharing the write port of the pixel FIFO between
// producer A (host SPI receiver) and producer B (pattern/overlay generator).
// A grant is held for a whole burst. A burst ends on a last word, or when
// MAX_BURST words have been taken, and then the grant is re-arbitrated.
//
// Ports
//   i_clock        FIFO write-side clock (rising edge)
//   i_reset        synchronous active-high reset
//   i_validA/B     producer has a word
//   i_dataA/B      producer word
//   i_lastA/B      word ends the producer's burst
//   o_readyA/B     word accepted this cycle when valid is also high
//   o_fifoData     word presented to the FIFO (0 when nobody owns the port)
//   o_fifoWrite    FIFO write strobe
//   i_fifoFull     FIFO full flag
//   o_grant        owner: 00 none, 01 A, 10 B
//   o_stallCycles  saturating count of owner-valid-while-full cycles
//
// state  | meaning
// IDLE   | no owner, arbitrating between pending producers
// OWN_A  | A owns the write port until its burst ends
// OWN_B  | B owns the write port until its burst ends

module fifo_write_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_validA,
  input  logic [DATA_WIDTH-1:0] i_dataA,
  input  logic                  i_lastA,
  output logic                  o_readyA,
  input  logic                  i_validB,
  input  logic [DATA_WIDTH-1:0] i_dataB,
  input  logic                  i_lastB,
  output logic                  o_readyB,
  output logic [DATA_WIDTH-1:0] o_fifoData,
  output logic                  o_fifoWrite,
  input  logic                  i_fifoFull,
  output logic [1:0]            o_grant,
  output logic [15:0]           o_stallCycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } state_t;

  localparam logic [7:0] BURST_CAP = 8'(MAX_BURST - 1);

  state_t      state;
  logic        last_served;   // 0 = A, 1 = B
  logic [7:0]  burst_cnt;
  logic [15:0] stall_cnt;

  logic own_a;
  logic own_b;
  logic accept_a;
  logic accept_b;
  logic accept;
  logic owner_valid;
  logic owner_last;
  logic burst_end;

  assign own_a = (state == OWN_A);
  assign own_b = (state == OWN_B);

  // Reset gates ready combinationally so a burst cut by reset never
  // produces a partial write in the reset cycle.
  assign o_readyA = own_a && !i_fifoFull && !i_reset;
  assign o_readyB = own_b && !i_fifoFull && !i_reset;

  assign accept_a    = i_validA && o_readyA;
  assign accept_b    = i_validB && o_readyB;
  assign accept      = accept_a || accept_b;
  assign owner_valid = (own_a && i_validA) || (own_b && i_validB);
  assign owner_last  = own_a ? i_lastA : i_lastB;
  assign burst_end   = accept && (owner_last || (burst_cnt == BURST_CAP));

  always_comb begin
    o_fifoData = '0;
    if (own_a)      o_fifoData = i_dataA;
    else if (own_b) o_fifoData = i_dataB;
  end

  assign o_fifoWrite   = accept;
  assign o_grant       = state;
  assign o_stallCycles = stall_cnt;

  // At burst end the other producer takes over if it is waiting. Otherwise a
  // burst cut by the length cap keeps the same owner (its stream continues),
  // while a burst finished by its last word releases the port to IDLE.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      burst_cnt   <= '0;
      stall_cnt   <= '0;
    end else begin
      if (owner_valid && i_fifoFull && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;

      case (state)
        IDLE: begin
          burst_cnt <= '0;
          if (i_validA && (!i_validB || last_served)) state <= OWN_A;
          else if (i_validB)                           state <= OWN_B;
        end
        OWN_A: begin
          if (burst_end) begin
            last_served <= 1'b0;
            burst_cnt   <= '0;
            if (i_validB)     state <= OWN_B;
            else if (!i_lastA) state <= OWN_A;
            else              state <= IDLE;
          end else if (accept_a) begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        OWN_B: begin
          if (burst_end) begin
            last_served <= 1'b1;
            burst_cnt   <= '0;
            if (i_validA)     state <= OWN_A;
            else if (!i_lastB) state <= OWN_B;
            else              state <= IDLE;
          end else if (accept_b) begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
module tb_fifo_write_arbiter;
  localparam int DW = 32;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_validA = 1'b0, i_lastA = 1'b0;
  logic [DW-1:0] i_dataA = '0;
  logic          i_validB = 1'b0, i_lastB = 1'b0;
  logic [DW-1:0] i_dataB = '0;
  logic          i_fifoFull = 1'b0;
  logic          o_readyA, o_readyB, o_fifoWrite;
  logic [DW-1:0] o_fifoData;
  logic [1:0]    o_grant;
  logic [15:0]   o_stallCycles;

  always #5 clk = ~clk;

  fifo_write_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_validA(i_validA), .i_dataA(i_dataA), .i_lastA(i_lastA), .o_readyA(o_readyA),
    .i_validB(i_validB), .i_dataB(i_dataB), .i_lastB(i_lastB), .o_readyB(o_readyB),
    .o_fifoData(o_fifoData), .o_fifoWrite(o_fifoWrite), .i_fifoFull(i_fifoFull),
    .o_grant(o_grant), .o_stallCycles(o_stallCycles)
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } word_t;

  word_t send_q[2][$];   // words the producer still has to hand over
  word_t exp_q[2][$];    // scoreboard: words expected at the FIFO, per producer
  bit    acc_pend[2];
  bit    bubble_en = 1'b0;
  bit    log_en = 1'b0;
  logic [DW:0] log_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  // burst-rule model: current owner mid-burst, required next writer, words so far
  int    cur = -1;
  int    must = -1;
  int    bc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_word(input int p, input logic [DW-1:0] d, input logic l);
    word_t w;
    w.last = l;
    w.data = d;
    send_q[p].push_back(w);
    exp_q[p].push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((send_q[0].size() != 0 || send_q[1].size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_within_budget", (n < budget), 1);
  endtask

  // Producer drivers: pop the word accepted in the previous cycle, present the next.
  always @(posedge clk) begin
    #2;
    for (int p = 0; p < 2; p++)
      if (acc_pend[p] && send_q[p].size() != 0) void'(send_q[p].pop_front());
    i_validA = (send_q[0].size() != 0) && !(bubble_en && $urandom_range(0, 4) == 0);
    i_dataA  = (send_q[0].size() != 0) ? send_q[0][0].data : '0;
    i_lastA  = (send_q[0].size() != 0) ? send_q[0][0].last : 1'b0;
    i_validB = (send_q[1].size() != 0) && !(bubble_en && $urandom_range(0, 4) == 0);
    i_dataB  = (send_q[1].size() != 0) ? send_q[1][0].data : '0;
    i_lastB  = (send_q[1].size() != 0) ? send_q[1][0].last : 1'b0;
  end

  // Monitor: pops the scoreboard on every FIFO write and checks burst rules.
  always @(negedge clk) begin
    int    w;
    word_t e;
    bit    oth_valid;
    acc_pend[0] = i_validA && o_readyA;
    acc_pend[1] = i_validB && o_readyB;
    if (i_reset) begin
      check("reset_no_write", o_fifoWrite, 0);
      check("reset_no_ready", {o_readyA, o_readyB}, 0);
      cur = -1;
      must = -1;
      bc = 0;
    end else begin
      if (i_fifoFull) check("full_no_write", o_fifoWrite, 0);
      if (o_readyA && o_readyB) check("ready_exclusive", 1, 0);
      if (o_fifoWrite) begin
        w = (o_grant == 2'b10) ? 1 : 0;
        check("write_has_owner", (o_grant == 2'b01 || o_grant == 2'b10), 1);
        if (cur >= 0)       check("burst_continuity", w, cur);
        else if (must >= 0) check("handover_target", w, must);
        if (exp_q[w].size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q[w].pop_front();
          check("write_data", o_fifoData, e.data);
          if (e.last || bc + 1 == MB) begin
            oth_valid = (w == 0) ? i_validB : i_validA;
            must = oth_valid ? 1 - w : (e.last ? -1 : w);
            cur = -1;
            bc = 0;
          end else begin
            cur = w;
            bc++;
          end
        end
        if (log_en) log_q.push_back({w[0], o_fifoData});
      end
    end
  end

  logic [DW-1:0] t1_words[3] = '{32'h11111111, 32'h22222222, 32'h33333333};
  logic [1:0]    t2_grant[4] = '{2'b01, 2'b01, 2'b10, 2'b10};
  logic [DW-1:0] t2_data[4]  = '{32'hA0000001, 32'hA0000002, 32'hB0000001, 32'hB0000002};

  initial begin
    logic [DW:0] exp_log;
    int          len;

    // reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_grant", o_grant, 0);
    check("rst_readyA", o_readyA, 0);
    check("rst_readyB", o_readyB, 0);
    check("rst_write", o_fifoWrite, 0);
    check("rst_stall", o_stallCycles, 0);
    check("rst_data", o_fifoData, 0);
    step();
    i_reset = 1'b0;

    // single 3-word A burst
    step();
    for (int i = 0; i < 3; i++) push_word(0, t1_words[i], i == 2);
    @(negedge clk);
    check("t1_idle_grant", o_grant, 2'b00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_grant", o_grant, 2'b01);
      check("t1_write", o_fifoWrite, 1);
      check("t1_data", o_fifoData, t1_words[i]);
    end
    @(negedge clk);
    check("t1_release", o_grant, 2'b00);
    check("t1_no_write", o_fifoWrite, 0);

    // simultaneous bursts from reset: A first, B with zero idle cycles
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    push_word(0, 32'hA0000001, 1'b0);
    push_word(0, 32'hA0000002, 1'b1);
    push_word(1, 32'hB0000001, 1'b0);
    push_word(1, 32'hB0000002, 1'b1);
    @(negedge clk);
    check("t2_idle_grant", o_grant, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_grant", o_grant, t2_grant[i]);
      check("t2_write", o_fifoWrite, 1);
      check("t2_data", o_fifoData, t2_data[i]);
    end
    @(negedge clk);
    check("t2_release", o_grant, 2'b00);

    // MAX_BURST forced re-arbitration
    step();
    log_q.delete();
    log_en = 1'b1;
    for (int i = 1; i <= 40; i++) push_word(0, 32'hA0000000 + i, 1'b0);
    for (int i = 1; i <= 3; i++)  push_word(1, 32'hB0000000 + i, i == 3);
    wait_drain(300);
    step();
    step();
    log_en = 1'b0;
    check("t3_count", log_q.size(), 43);
    len = (log_q.size() < 43) ? log_q.size() : 43;
    for (int i = 0; i < len; i++) begin
      if (i < 16)      exp_log = {1'b0, 32'hA0000000 + i + 1};
      else if (i < 19) exp_log = {1'b1, 32'hB0000000 + i - 15};
      else             exp_log = {1'b0, 32'hA0000000 + i - 2};
      check("t3_order", log_q[i], exp_log);
    end
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;

    // FIFO full for 5 cycles mid-burst
    step();
    for (int i = 1; i <= 6; i++) push_word(0, 32'hC0000000 + i, i == 6);
    step();
    step();
    i_fifoFull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_full_write", o_fifoWrite, 0);
      check("t4_full_readyA", o_readyA, 0);
    end
    step();
    i_fifoFull = 1'b0;
    @(negedge clk);
    check("t4_resume_write", o_fifoWrite, 1);
    check("t4_resume_data", o_fifoData, 32'hC0000002);
    check("t4_stall", o_stallCycles, 5);
    wait_drain(50);

    // reset during word 2 of a B burst; A must win the following tie
    step();
    for (int i = 1; i <= 4; i++) push_word(1, 32'hD0000000 + i, i == 4);
    step();
    step();
    i_reset = 1'b1;
    push_word(0, 32'hE0000001, 1'b0);
    push_word(0, 32'hE0000002, 1'b1);
    @(negedge clk);
    check("t5_rst_write", o_fifoWrite, 0);
    check("t5_rst_readyB", o_readyB, 0);
    step();
    i_reset = 1'b0;
    @(negedge clk);
    check("t5_grant_none", o_grant, 2'b00);
    check("t5_stall_clr", o_stallCycles, 0);
    @(negedge clk);
    check("t5_tie_to_A", o_grant, 2'b01);
    wait_drain(50);

    // randomized traffic with full, bubbles and long bursts
    bubble_en = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      step();
      i_fifoFull = ($urandom_range(0, 4) == 0);
      for (int p = 0; p < 2; p++) begin
        if (send_q[p].size() == 0 && $urandom_range(0, 7) == 0) begin
          len = $urandom_range(1, 20);
          for (int k = 0; k < len; k++) push_word(p, $urandom, k == len - 1);
        end
      end
    end
    step();
    i_fifoFull = 1'b0;
    bubble_en = 1'b0;
    wait_drain(2000);

    // stall counter saturation
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    push_word(0, 32'hF0000001, 1'b0);
    push_word(0, 32'hF0000002, 1'b1);
    i_fifoFull = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    check("t6_stall_sat", o_stallCycles, 16'hFFFF);
    check("t6_no_write", o_fifoWrite, 0);
    step();
    i_fifoFull = 1'b0;
    wait_drain(50);
    step();
    step();

    check("end_expA_empty", exp_q[0].size(), 0);
    check("end_expB_empty", exp_q[1].size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
